// File: rtl/interleave_pkg.sv
// interleave_pkg: shared FSM state type and expected follow/invert pattern
package interleave_pkg;
  typedef enum logic [2:0] {IDLE, SET0, SET1, CHECK, DONE} state_t;
  function automatic logic [63:0] exp_pattern(input logic s, input int width);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) v[i] = (i < width) ? s ^ i[0] : 1'b0;
    return v;
  endfunction
endpackage

// File: rtl/interleave_popcount.sv
// interleave_popcount: combinational count of set bits
module interleave_popcount #(
  parameter int W = 12
) (
  input  logic [W-1:0]           v,
  output logic [$clog2(W+1)-1:0] n
);
  localparam int OW = $clog2(W+1);
  // sum the ones of the mismatch vector
  always_comb begin
    n = '0;
    for (int i = 0; i < W; i++) n = n + OW'(v[i]);
  end
endmodule

// File: rtl/interleave_capture.sv
// interleave_capture: drives a 0 then 1 stimulus phase, samples and checks the DUT pattern
module interleave_capture
  import interleave_pkg::*;
#(
  parameter int BW = 8,
  parameter int CW = 4,
  parameter int SETTLE_CYC = 2,
  parameter int ERR_W = $clog2(2*(BW+CW)+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic             busy_o,
  output logic             stim_o,
  input  logic [BW-1:0]    b_i,
  input  logic [CW-1:0]    c_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             res_pass_o,
  output logic [ERR_W-1:0] res_err_o,
  output logic [BW+CW-1:0] res_mask_o
);
  localparam int N = BW + CW;
  localparam int PW = $clog2(N+1);
  localparam int SW = $clog2(SETTLE_CYC+1);
  localparam logic [SW-1:0] LAST = SW'(SETTLE_CYC-1);
  state_t state;
  logic [SW-1:0] cnt;
  logic [N-1:0] obs, exp_v, mm, m0, m1;
  logic [PW-1:0] p0, p1;
  assign obs = {c_i, b_i};
  assign exp_v = {CW'(exp_pattern(stim_o, CW)), BW'(exp_pattern(stim_o, BW))};
  // case inequality so X/Z on an input bit is flagged as a mismatch
  always_comb begin
    mm = '0;
    for (int i = 0; i < N; i++) mm[i] = (obs[i] !== exp_v[i]);
  end
  interleave_popcount #(.W(N)) u_pc0 (.v(m0), .n(p0));
  interleave_popcount #(.W(N)) u_pc1 (.v(m1), .n(p1));
  // phase sequencing, sampling and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      m0 <= '0;
      m1 <= '0;
      busy_o <= 1'b0;
      stim_o <= 1'b0;
      res_valid_o <= 1'b0;
      res_pass_o <= 1'b0;
      res_err_o <= '0;
      res_mask_o <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          state <= SET0;
          cnt <= '0;
          busy_o <= 1'b1;
        end
        SET0: if (cnt == LAST) begin
          m0 <= mm;
          cnt <= '0;
          stim_o <= 1'b1;
          state <= SET1;
        end else cnt <= cnt + 1'b1;
        SET1: if (cnt == LAST) begin
          m1 <= mm;
          cnt <= '0;
          state <= CHECK;
        end else cnt <= cnt + 1'b1;
        CHECK: begin
          res_mask_o <= m0 | m1;
          res_err_o <= ERR_W'(p0) + ERR_W'(p1);
          res_pass_o <= (p0 == '0) && (p1 == '0);
          res_valid_o <= 1'b1;
          busy_o <= 1'b0;
          state <= DONE;
        end
        DONE: if (res_ready_i) begin
          res_valid_o <= 1'b0;
          stim_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
